// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: parametrised multi-item coin vending controller.
// Credit builds from batched low/high-denomination deposits. Any of NUM_ITEMS
// items is sold at a table-set price. Change is paid one coin per cycle,
// highest denomination first.
// Optional feature: define VEND_TIMEOUT_EN to enable an idle counter in CREDIT.
// When the counter reaches TIMEOUT_CYC it pulses timeout_flag and refunds the
// full credit. Without the macro, credit is held indefinitely and
// timeout_flag is tied low.
module vend_ctrl_multi #(
  parameter int                           NUM_ITEMS   = 4,
  parameter int                           PRICE_W     = 8,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_TABLE = 32'h281E190F,
  parameter int                           COIN_W      = 4,
  parameter int                           CREDIT_W    = 8,
  parameter int                           DENOM_LO    = 5,
  parameter int                           DENOM_HI    = 10,
  parameter int                           TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         coin_valid,
  input  logic [COIN_W-1:0]            coin_lo_cnt,
  input  logic [COIN_W-1:0]            coin_hi_cnt,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_idx,
  input  logic                         cancel,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy,
  output logic                         dispense_valid,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_idx,
  output logic                         change_hi,
  output logic                         change_lo,
  output logic                         coin_reject,
  output logic                         err_insufficient,
  output logic                         timeout_flag
);

  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam int VAL_W = CREDIT_W + 1;
  localparam int SUM_W = CREDIT_W + 2;
  localparam int CMP_W = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;

  localparam logic [SUM_W-1:0]    CREDIT_MAX_X = {2'b00, {CREDIT_W{1'b1}}};
  localparam logic [VAL_W-1:0]    LO_V         = VAL_W'(DENOM_LO);
  localparam logic [VAL_W-1:0]    HI_V         = VAL_W'(DENOM_HI);
  localparam logic [CREDIT_W-1:0] LO_C         = CREDIT_W'(DENOM_LO);
  localparam logic [CREDIT_W-1:0] HI_C         = CREDIT_W'(DENOM_HI);
  localparam logic [SEL_W:0]      IDX_LIMIT    = (SEL_W+1)'(NUM_ITEMS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  // Price lookup from the packed table; unknown indices read as zero.
  function automatic logic [PRICE_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    logic [PRICE_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (idx == SEL_W'(i)) begin
        p = PRICE_TABLE[i*PRICE_W +: PRICE_W];
      end
    end
    return p;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
  logic                busy_r;
  logic                dv_r, dv_nxt_s;
  logic [SEL_W-1:0]    idx_r, idx_nxt_s;
  logic                chi_r, chi_nxt_s;
  logic                clo_r, clo_nxt_s;
  logic                rej_r, rej_nxt_s;
  logic                err_r, err_nxt_s;
  logic                to_nxt_s;

  logic [VAL_W-1:0]    value_s;
  logic [SUM_W-1:0]    sum_s;
  logic                over_s;
  logic [PRICE_W-1:0]  price_s;
  logic [CREDIT_W-1:0] price_c_s;
  logic                sel_ok_s;
  logic                step_hi_s;
  logic [CREDIT_W-1:0] change_rem_s;

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic            timeout_r;
`endif

  // Deposit arithmetic, overflow detection and purchase qualification.
  always_comb begin
    value_s   = VAL_W'(coin_lo_cnt) * LO_V + VAL_W'(coin_hi_cnt) * HI_V;
    sum_s     = {1'b0, value_s} + {2'b00, credit_r};
    over_s    = (sum_s > CREDIT_MAX_X);
    price_s   = price_of(sel_idx);
    price_c_s = CREDIT_W'(price_s);
    sel_ok_s  = ({1'b0, sel_idx} < IDX_LIMIT) &&
                (CMP_W'(credit_r) >= CMP_W'(price_s));
  end

  // One change coin: high denomination when it fits, else low.
  always_comb begin
    step_hi_s = (credit_r >= HI_C);
    if (step_hi_s) begin
      change_rem_s = credit_r - HI_C;
    end else if (credit_r >= LO_C) begin
      change_rem_s = credit_r - LO_C;
    end else begin
      change_rem_s = '0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    dv_nxt_s     = 1'b0;
    idx_nxt_s    = idx_r;
    chi_nxt_s    = 1'b0;
    clo_nxt_s    = 1'b0;
    rej_nxt_s    = 1'b0;
    err_nxt_s    = 1'b0;
    to_nxt_s     = 1'b0;
`ifdef VEND_TIMEOUT_EN
    idle_cnt_nxt_s = '0;
`endif
    case (state_r)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          if (state_r == ST_CREDIT) begin
            state_nxt_s = ST_CHANGE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (coin_valid) begin
          if (value_s == '0) begin
            credit_nxt_s = credit_r;
          end else if (over_s) begin
            rej_nxt_s = 1'b1;
          end else begin
            credit_nxt_s = sum_s[CREDIT_W-1:0];
            state_nxt_s  = ST_CREDIT;
          end
        end else if (sel_valid) begin
          if ((state_r == ST_CREDIT) && sel_ok_s) begin
            state_nxt_s  = ST_VEND;
            dv_nxt_s     = 1'b1;
            idx_nxt_s    = sel_idx;
            credit_nxt_s = credit_r - price_c_s;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
`ifdef VEND_TIMEOUT_EN
          if (state_r == ST_CREDIT) begin
            if (idle_cnt_r >= TO_LAST) begin
              to_nxt_s    = 1'b1;
              state_nxt_s = ST_CHANGE;
            end else begin
              idle_cnt_nxt_s = idle_cnt_r + TO_W'(1);
            end
          end else begin
            idle_cnt_nxt_s = '0;
          end
`else
          state_nxt_s = state_r;
`endif
        end
      end
      ST_VEND, ST_CHANGE: begin
        if (credit_r == '0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          chi_nxt_s    = step_hi_s;
          clo_nxt_s    = ~step_hi_s;
          credit_nxt_s = change_rem_s;
          if (change_rem_s == '0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_CHANGE;
          end
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        credit_nxt_s = '0;
      end
    endcase
  end

  // FSM state, credit and registered output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      credit_r <= '0;
      busy_r   <= 1'b0;
      dv_r     <= 1'b0;
      idx_r    <= '0;
      chi_r    <= 1'b0;
      clo_r    <= 1'b0;
      rej_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      busy_r   <= (state_nxt_s == ST_VEND) || (state_nxt_s == ST_CHANGE);
      dv_r     <= dv_nxt_s;
      idx_r    <= idx_nxt_s;
      chi_r    <= chi_nxt_s;
      clo_r    <= clo_nxt_s;
      rej_r    <= rej_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

`ifdef VEND_TIMEOUT_EN
  // Idle counter and auto-refund pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt_s;
      timeout_r  <= to_nxt_s;
    end
  end
  assign timeout_flag = timeout_r;
`else
  assign timeout_flag = 1'b0;
`endif

  assign credit           = credit_r;
  assign busy             = busy_r;
  assign dispense_valid   = dv_r;
  assign dispense_idx     = idx_r;
  assign change_hi        = chi_r;
  assign change_lo        = clo_r;
  assign coin_reject      = rej_r;
  assign err_insufficient = err_r;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed testbench for vend_ctrl_multi (default prices 15,25,30,40).
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_valid;
  logic [3:0] coin_lo_cnt;
  logic [3:0] coin_hi_cnt;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       cancel;
  logic [7:0] credit;
  logic       busy;
  logic       dispense_valid;
  logic [1:0] dispense_idx;
  logic       change_hi;
  logic       change_lo;
  logic       coin_reject;
  logic       err_insufficient;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;

  vend_ctrl_multi #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid),
    .coin_lo_cnt(coin_lo_cnt), .coin_hi_cnt(coin_hi_cnt),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .credit(credit), .busy(busy), .dispense_valid(dispense_valid),
    .dispense_idx(dispense_idx), .change_hi(change_hi), .change_lo(change_lo),
    .coin_reject(coin_reject), .err_insufficient(err_insufficient),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    coin_valid = 1'b0; coin_lo_cnt = 4'd0; coin_hi_cnt = 4'd0;
    sel_valid = 1'b0; sel_idx = 2'd0; cancel = 1'b0;
  endtask

  task automatic deposit(input logic [3:0] lo, input logic [3:0] hi);
    coin_valid = 1'b1; coin_lo_cnt = lo; coin_hi_cnt = hi;
    tick();
    idle_in();
  endtask

  task automatic select(input logic [1:0] idx);
    sel_valid = 1'b1; sel_idx = idx;
    tick();
    idle_in();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    idle_in();
  endtask

  task automatic apply_reset();
    idle_in();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    idle_in();
    reset_n = 1'b0;
    tick();
    outs = {credit, busy, dispense_valid, dispense_idx, change_hi, change_lo,
            coin_reject, err_insufficient, timeout_flag};
    total++; if (outs !== 18'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
    reset_n = 1'b1;
    tick();
    total++; if ({credit, busy} !== 9'd0) begin bad++; $display("FAIL reset_release got=%h exp=0", {credit, busy}); end
  endtask

  task automatic test_vend_lo_change();
    apply_reset();
    deposit(4'd1, 4'd4);
    total++; if (credit !== 8'd45) begin bad++; $display("FAIL t1_credit got=%0d exp=45", credit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_credit got=%b exp=0", busy); end
    select(2'd3);
    total++; if ({dispense_valid, dispense_idx} !== 3'b111) begin bad++; $display("FAIL t1_dispense got=%b exp=111", {dispense_valid, dispense_idx}); end
    total++; if (credit !== 8'd5) begin bad++; $display("FAIL t1_credit_vend got=%0d exp=5", credit); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_vend got=%b exp=1", busy); end
    tick();
    total++; if ({change_hi, change_lo, dispense_valid} !== 3'b010) begin bad++; $display("FAIL t1_change got=%b exp=010", {change_hi, change_lo, dispense_valid}); end
    total++; if (credit !== 8'd0) begin bad++; $display("FAIL t1_credit_end got=%0d exp=0", credit); end
    tick();
    total++; if ({change_lo, busy, dispense_idx} !== 4'b0011) begin bad++; $display("FAIL t1_idle got=%b exp=0011", {change_lo, busy, dispense_idx}); end
  endtask

  task automatic test_insufficient_cancel();
    apply_reset();
    deposit(4'd1, 4'd1);
    select(2'd3);
    total++; if ({err_insufficient, dispense_valid, busy} !== 3'b100) begin bad++; $display("FAIL t2_err got=%b exp=100", {err_insufficient, dispense_valid, busy}); end
    total++; if (credit !== 8'd15) begin bad++; $display("FAIL t2_credit got=%0d exp=15", credit); end
    tick();
    total++; if (err_insufficient !== 1'b0) begin bad++; $display("FAIL t2_err_pulse got=%b exp=0", err_insufficient); end
    do_cancel();
    total++; if ({busy, change_hi, change_lo, credit} !== {3'b100, 8'd15}) begin bad++; $display("FAIL t2_cancel got=%b exp=100_15", {busy, change_hi, change_lo, credit}); end
    tick();
    total++; if ({change_hi, change_lo, credit} !== {2'b10, 8'd5}) begin bad++; $display("FAIL t2_chg_hi got=%b exp=10_5", {change_hi, change_lo, credit}); end
    tick();
    total++; if ({change_hi, change_lo, credit} !== {2'b01, 8'd0}) begin bad++; $display("FAIL t2_chg_lo got=%b exp=01_0", {change_hi, change_lo, credit}); end
    tick();
    total++; if ({change_hi, change_lo, busy} !== 3'b000) begin bad++; $display("FAIL t2_done got=%b exp=000", {change_hi, change_lo, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_cr [3];
    exp_cr[0] = 8'd20; exp_cr[1] = 8'd10; exp_cr[2] = 8'd0;
    apply_reset();
    deposit(4'd4, 4'd4);
    total++; if (credit !== 8'd60) begin bad++; $display("FAIL t3_credit got=%0d exp=60", credit); end
    select(2'd2);
    total++; if ({dispense_valid, dispense_idx, credit} !== {3'b110, 8'd30}) begin bad++; $display("FAIL t3_dispense got=%b exp=110_30", {dispense_valid, dispense_idx, credit}); end
    coin_valid = 1'b1; coin_lo_cnt = 4'd2; cancel = 1'b1; sel_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_in();
      total++; if ({change_hi, change_lo, credit, coin_reject, err_insufficient} !== {2'b10, exp_cr[i], 2'b00}) begin
        bad++; $display("FAIL t3_hi%0d got=%b exp=10_%0d_00", i, {change_hi, change_lo, credit, coin_reject, err_insufficient}, exp_cr[i]);
      end
    end
    tick();
    total++; if ({change_hi, busy, credit} !== 10'd0) begin bad++; $display("FAIL t3_done got=%b exp=0", {change_hi, busy, credit}); end
  endtask

  task automatic test_overflow();
    int n_hi, n_lo, n_both;
    n_hi = 0; n_lo = 0; n_both = 0;
    apply_reset();
    deposit(4'd15, 4'd15);
    total++; if (credit !== 8'd225) begin bad++; $display("FAIL t4_credit got=%0d exp=225", credit); end
    deposit(4'd0, 4'd4);
    total++; if ({coin_reject, credit} !== {1'b1, 8'd225}) begin bad++; $display("FAIL t4_reject got=%b exp=1_225", {coin_reject, credit}); end
    tick();
    total++; if (coin_reject !== 1'b0) begin bad++; $display("FAIL t4_reject_pulse got=%b exp=0", coin_reject); end
    select(2'd0);
    total++; if ({dispense_valid, dispense_idx, credit} !== {3'b100, 8'd210}) begin bad++; $display("FAIL t4_dispense got=%b exp=100_210", {dispense_valid, dispense_idx, credit}); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (change_hi) n_hi++;
      if (change_lo) n_lo++;
      if (change_hi && change_lo) n_both++;
    end
    total++; if (n_hi != 21) begin bad++; $display("FAIL t4_hi_count got=%0d exp=21", n_hi); end
    total++; if ({n_lo, n_both} != 64'd0) begin bad++; $display("FAIL t4_lo_both got=%0d/%0d exp=0/0", n_lo, n_both); end
    total++; if ({credit, busy} !== 9'd0) begin bad++; $display("FAIL t4_end got=%b exp=0", {credit, busy}); end
  endtask

  task automatic test_priority();
    apply_reset();
    deposit(4'd2, 4'd0);
    cancel = 1'b1; coin_valid = 1'b1; coin_lo_cnt = 4'd1; sel_valid = 1'b1; sel_idx = 2'd0;
    tick();
    idle_in();
    total++; if ({busy, credit, dispense_valid, err_insufficient} !== {1'b1, 8'd10, 2'b00}) begin bad++; $display("FAIL prio_cancel got=%b exp=1_10_00", {busy, credit, dispense_valid, err_insufficient}); end
    tick();
    total++; if ({change_hi, credit} !== {1'b1, 8'd0}) begin bad++; $display("FAIL prio_refund got=%b exp=1_0", {change_hi, credit}); end
    tick();
    deposit(4'd0, 4'd3);
    coin_valid = 1'b1; coin_lo_cnt = 4'd1; sel_valid = 1'b1; sel_idx = 2'd0;
    tick();
    idle_in();
    total++; if ({credit, dispense_valid, busy, err_insufficient} !== {8'd35, 3'b000}) begin bad++; $display("FAIL prio_coin got=%b exp=35_000", {credit, dispense_valid, busy, err_insufficient}); end
    apply_reset();
    deposit(4'd0, 4'd0);
    total++; if ({credit, busy, coin_reject} !== 10'd0) begin bad++; $display("FAIL zero_deposit got=%b exp=0", {credit, busy, coin_reject}); end
    select(2'd1);
    total++; if ({err_insufficient, dispense_valid} !== 2'b10) begin bad++; $display("FAIL idle_sel got=%b exp=10", {err_insufficient, dispense_valid}); end
    do_cancel();
    total++; if ({busy, credit, err_insufficient} !== 10'd0) begin bad++; $display("FAIL idle_cancel got=%b exp=0", {busy, credit, err_insufficient}); end
  endtask

  task automatic test_reset_midchange();
    int n_act;
    logic [17:0] outs;
    n_act = 0;
    apply_reset();
    deposit(4'd4, 4'd4);
    do_cancel();
    tick();
    tick();
    total++; if ({change_hi, credit} !== {1'b1, 8'd40}) begin bad++; $display("FAIL t5_second_hi got=%b exp=1_40", {change_hi, credit}); end
    #2;
    reset_n = 1'b0;
    #1;
    outs = {credit, busy, dispense_valid, dispense_idx, change_hi, change_lo,
            coin_reject, err_insufficient, timeout_flag};
    total++; if (outs !== 18'd0) begin bad++; $display("FAIL t5_async_reset got=%h exp=0", outs); end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (change_hi || change_lo || busy || dispense_valid || credit != 8'd0) n_act++;
    end
    total++; if (n_act != 0) begin bad++; $display("FAIL t5_after_release got=%0d exp=0", n_act); end
  endtask

  task automatic test_timeout();
    int n_ev;
    n_ev = 0;
    apply_reset();
    deposit(4'd0, 4'd2);
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout_flag || busy) n_ev++;
    end
    total++; if (n_ev != 0) begin bad++; $display("FAIL t6_early got=%0d exp=0", n_ev); end
    tick();
    total++; if ({timeout_flag, busy, credit} !== {2'b11, 8'd20}) begin bad++; $display("FAIL t6_flag got=%b exp=11_20", {timeout_flag, busy, credit}); end
    tick();
    total++; if ({change_hi, timeout_flag, credit} !== {2'b10, 8'd10}) begin bad++; $display("FAIL t6_hi1 got=%b exp=10_10", {change_hi, timeout_flag, credit}); end
    tick();
    total++; if ({change_hi, credit} !== {1'b1, 8'd0}) begin bad++; $display("FAIL t6_hi2 got=%b exp=1_0", {change_hi, credit}); end
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout_flag || busy || change_hi || change_lo) n_ev++;
    end
    total++; if (n_ev != 0) begin bad++; $display("FAIL t6_no_timeout got=%0d exp=0", n_ev); end
    total++; if (credit !== 8'd20) begin bad++; $display("FAIL t6_held got=%0d exp=20", credit); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    test_reset();
    test_vend_lo_change();
    test_insufficient_cancel();
    test_back_to_back();
    test_overflow();
    test_priority();
    test_reset_midchange();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
